// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage. Assembles 32-bit little-endian words
// from a byte-wide instruction read port, tracks the PC, presents
// {flag_o, pc_o, inst_o} to IF/ID and honours stalls and EX redirects.
// Optional feature macro: ICACHE_EN enables a direct-mapped word cache of
// ICACHE_LINES lines that bypasses the byte sequence on hits.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting to start a fetch (memory may be busy)
// RD0-RD3 | byte k of the word requested; byte k-1 arrives
// WAIT    | last byte arrives from memory
// DONE    | instruction held on flag_o/pc_o/inst_o

module if_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          ICACHE_LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    input  logic        mem_busy_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [7:0]  mem_rdata_i,
    output logic        flag_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_RD2,
        ST_RD3,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [23:0] byte_buf;
    logic [31:0] pc_next4;
    logic        cache_hit;
    logic [31:0] cache_word;

    assign pc_next4 = pc + 32'd4;

    // Cache indexing needs at least one index bit and a power-of-two size.
    if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_bad_lines
        $error("ICACHE_LINES must be a power of two of at least 2");
    end

`ifdef ICACHE_EN
    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = 30 - IDX_W;

    logic [31:0]             cache_data [ICACHE_LINES];
    logic [TAG_W-1:0]        cache_tag  [ICACHE_LINES];
    logic [ICACHE_LINES-1:0] cache_valid;
    logic [31:0]             lookup_addr;
    logic [IDX_W-1:0]        lookup_idx;
    logic [TAG_W-1:0]        lookup_tag;
    logic [IDX_W-1:0]        fill_idx;
    logic [TAG_W-1:0]        fill_tag;
    logic                    fill_en;

    // In DONE the lookup is for the instruction after the one being consumed.
    always_comb begin
        lookup_addr = (state == ST_DONE) ? pc_next4 : pc;
        lookup_idx  = lookup_addr[IDX_W+1:2];
        lookup_tag  = lookup_addr[31:IDX_W+2];
        cache_hit   = cache_valid[lookup_idx] && (cache_tag[lookup_idx] == lookup_tag);
        cache_word  = cache_data[lookup_idx];
    end

    assign fill_idx = pc[IDX_W+1:2];
    assign fill_tag = pc[31:IDX_W+2];
    // The word is complete in WAIT even if a jump arrives, so the fill is not gated.
    assign fill_en  = (state == ST_WAIT);

    // Line data and tag written when the last byte returns.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            cache_data[fill_idx] <= {mem_rdata_i, byte_buf};
            cache_tag[fill_idx]  <= fill_tag;
        end
    end

    // Valid bits: cleared only by reset, never by jumps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cache_valid <= '0;
        end else if (fill_en) begin
            cache_valid[fill_idx] <= 1'b1;
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cache_word = 32'h0;
`endif

    // Fetch sequencer with registered memory request and IF/ID outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            byte_buf   <= '0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
            flag_o     <= 1'b0;
            pc_o       <= '0;
            inst_o     <= '0;
        end else if (jump_i) begin
            state      <= ST_IDLE;
            pc         <= jump_addr_i;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
            flag_o     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cache_hit) begin
                        state  <= ST_DONE;
                        inst_o <= cache_word;
                        pc_o   <= pc;
                        flag_o <= 1'b1;
                    end else if (!mem_busy_i) begin
                        state      <= ST_RD0;
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= pc;
                    end
                end
                ST_RD0: begin
                    state      <= ST_RD1;
                    mem_addr_o <= pc + 32'd1;
                end
                ST_RD1: begin
                    byte_buf[7:0] <= mem_rdata_i;
                    state         <= ST_RD2;
                    mem_addr_o    <= pc + 32'd2;
                end
                ST_RD2: begin
                    byte_buf[15:8] <= mem_rdata_i;
                    state          <= ST_RD3;
                    mem_addr_o     <= pc + 32'd3;
                end
                ST_RD3: begin
                    byte_buf[23:16] <= mem_rdata_i;
                    state           <= ST_WAIT;
                    mem_req_o       <= 1'b0;
                    mem_addr_o      <= '0;
                end
                ST_WAIT: begin
                    state  <= ST_DONE;
                    inst_o <= {mem_rdata_i, byte_buf};
                    pc_o   <= pc;
                    flag_o <= 1'b1;
                end
                ST_DONE: begin
                    if (!stall_i) begin
                        pc <= pc_next4;
                        if (cache_hit) begin
                            inst_o <= cache_word;
                            pc_o   <= pc_next4;
                        end else begin
                            flag_o <= 1'b0;
                            if (!mem_busy_i) begin
                                state      <= ST_RD0;
                                mem_req_o  <= 1'b1;
                                mem_addr_o <= pc_next4;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    mem_req_o  <= 1'b0;
                    mem_addr_o <= '0;
                    flag_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule
